mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mul_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// mul_arbiter: lets NREQ requesters share one multi-cycle multiplier, one operation in flight.
// Optional macro MUL_ARB_RR_EN selects round-robin grant; without it, grant is fixed priority (lowest index).
module mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int TAG_W   = 5,
  parameter int MUL_LAT = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*32-1:0]      req_a,
  input  logic [NREQ*32-1:0]      req_b,
  input  logic [NREQ*TAG_W-1:0]   req_tag,
  output logic                    fu_en,
  output logic [31:0]             fu_a,
  output logic [31:0]             fu_b,
  input  logic [31:0]             fu_res,
  input  logic                    fu_finish,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic [31:0]             rsp_data,
  output logic                    busy
);
  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(MUL_LAT + 1);

  typedef enum logic [2:0] {
    S_DRAIN = 3'd0,
    S_IDLE  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_data;
  logic [TAG_W-1:0] r_tag;
  logic [ID_W-1:0]  r_id;
  logic             w_accept;
  logic [ID_W-1:0]  w_gnt;
  logic [31:0]      w_sel_a;
  logic [31:0]      w_sel_b;
  logic [TAG_W-1:0] w_sel_tag;

  assign w_accept = (r_state == S_IDLE) && (|req_valid);

`ifdef MUL_ARB_RR_EN
  logic [ID_W-1:0] r_ptr;

  // Round-robin search: the first valid requester after the last grant wins.
  always_comb begin
    w_gnt = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_gnt = req_valid[(int'(r_ptr) + k) % NREQ] ? ID_W'((int'(r_ptr) + k) % NREQ) : w_gnt;
    end
  end

  // Pointer remembers the most recently accepted requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= ID_W'(NREQ - 1);
    end else if (w_accept) begin
      r_ptr <= w_gnt;
    end
  end
`else
  // Fixed priority: the lowest-indexed valid requester wins.
  always_comb begin
    w_gnt = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_gnt = req_valid[i] ? ID_W'(i) : w_gnt;
    end
  end
`endif

  // Select the granted requester's payload and raise its ready.
  always_comb begin
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_tag = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sel_a      = (w_gnt == ID_W'(i)) ? req_a[i*32 +: 32] : w_sel_a;
      w_sel_b      = (w_gnt == ID_W'(i)) ? req_b[i*32 +: 32] : w_sel_b;
      w_sel_tag    = (w_gnt == ID_W'(i)) ? req_tag[i*TAG_W +: TAG_W] : w_sel_tag;
      req_ready[i] = w_accept && (w_gnt == ID_W'(i));
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_DRAIN: begin
        if (r_cnt <= CNT_W'(1)) w_state_nxt = S_IDLE;
        else                    w_state_nxt = S_DRAIN;
      end
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_ISSUE;
        else          w_state_nxt = S_IDLE;
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (fu_finish) w_state_nxt = S_HOLD;
        else           w_state_nxt = S_WAIT;
      end
      S_HOLD: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
        else           w_state_nxt = S_HOLD;
      end
      default: w_state_nxt = S_DRAIN;
    endcase
  end

  // State register and drain counter; the unit has no reset, so wait out any old operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_DRAIN;
      r_cnt   <= CNT_W'(MUL_LAT);
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_DRAIN) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Operand/tag/owner latches and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_tag  <= '0;
      r_id   <= '0;
      r_data <= '0;
    end else begin
      if (w_accept) begin
        r_a   <= w_sel_a;
        r_b   <= w_sel_b;
        r_tag <= w_sel_tag;
        r_id  <= w_gnt;
      end
      if ((r_state == S_WAIT) && fu_finish) begin
        r_data <= fu_res;
      end
    end
  end

  assign fu_en     = (r_state == S_ISSUE);
  assign fu_a      = r_a;
  assign fu_b      = r_b;
  assign rsp_valid = (r_state == S_HOLD);
  assign rsp_id    = r_id;
  assign rsp_tag   = r_tag;
  assign rsp_data  = r_data;
  assign busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: a fixed-latency multiplier model plus a transaction-level
// reference (grant rule, product arithmetic, fixed latency) driven by directed and random stimulus.
module tb_mul_arbiter;
  localparam int NREQ    = 4;
  localparam int TAG_W   = 5;
  localparam int MUL_LAT = 7;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*32-1:0]    req_a = '0;
  logic [NREQ*32-1:0]    req_b = '0;
  logic [NREQ*TAG_W-1:0] req_tag = '0;
  logic                  fu_en;
  logic [31:0]           fu_a;
  logic [31:0]           fu_b;
  logic [31:0]           fu_res;
  logic                  fu_finish;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [ID_W-1:0]       rsp_id;
  logic [TAG_W-1:0]      rsp_tag;
  logic [31:0]           rsp_data;
  logic                  busy;

  int n_cmp = 0;
  int n_mis = 0;
  int m_ptr = NREQ - 1;
  logic tb_spur = 1'b0;

  mul_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .fu_en(fu_en), .fu_a(fu_a),
    .fu_b(fu_b), .fu_res(fu_res), .fu_finish(fu_finish), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier model: no reset, result MUL_LAT cycles after fu_en.
  logic [MUL_LAT-1:0] pipe_v = '0;
  logic [31:0]        pipe_d [MUL_LAT];
  always @(posedge clk) begin
    pipe_v    <= {pipe_v[MUL_LAT-2:0], fu_en};
    pipe_d[0] <= fu_a * fu_b;
    for (int i = 1; i < MUL_LAT; i++) pipe_d[i] <= pipe_d[i-1];
  end
  assign fu_finish = pipe_v[MUL_LAT-1] | tb_spur;
  assign fu_res    = tb_spur ? 32'hDEAD_BEEF : pipe_d[MUL_LAT-1];

  task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
`ifdef MUL_ARB_RR_EN
    for (int k = 1; k <= NREQ; k++) if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
`else
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
`endif
    return -1;
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    req_a[i*32 +: 32]       = a;
    req_b[i*32 +: 32]       = b;
    req_tag[i*TAG_W +: TAG_W] = t;
  endtask

  // Reset for 'low' edges, then follow the drain with spurious finishes injected.
  task automatic do_reset(input string nm, input int low);
    int n;
    rst_n = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b0;
    repeat (low) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ptr = NREQ - 1;
    check_value({nm, "_busy"}, busy, 1);
    check_value({nm, "_data_clr"}, rsp_data, 0);
    n = 0;
    while (busy && n < 20) begin
      check_value({nm, "_ready"}, req_ready, 0);
      check_value({nm, "_fu_en"}, fu_en, 0);
      check_value({nm, "_rsp_valid"}, rsp_valid, 0);
      tb_spur = (n == 2);
      @(posedge clk);
      #1;
      n++;
    end
    tb_spur = 1'b0;
    check_value({nm, "_drain_len"}, n, MUL_LAT);
    check_value({nm, "_idle_ready"}, req_ready, 64'(1) << model_grant('1, m_ptr));
    check_value({nm, "_idle_data"}, rsp_data, 0);
    req_valid = '0;
  endtask

  // One transaction from the IDLE cycle through the response handshake.
  task automatic do_txn(input string nm, input logic [NREQ-1:0] vld, input logic [NREQ-1:0] after_vld,
                        input int hold, input logic [NREQ-1:0] hold_vld,
                        output int gid_o, output logic [31:0] data_o);
    int gid, cyc, fin_cyc;
    logic [31:0] ea, eb, ep;
    logic [TAG_W-1:0] et;
    logic [63:0] prod;
    req_valid = vld;
    rsp_ready = 1'b0;
    #1;
    gid  = model_grant(vld, m_ptr);
    check_value({nm, "_grant"}, req_ready, 64'(1) << gid);
    ea   = req_a[gid*32 +: 32];
    eb   = req_b[gid*32 +: 32];
    et   = req_tag[gid*TAG_W +: TAG_W];
    prod = 64'(ea) * 64'(eb);
    ep   = prod[31:0];
    m_ptr = gid;
    @(posedge clk);
    #1;
    cyc = 1;
    fin_cyc = -1;
    req_valid = after_vld;
    check_value({nm, "_fu_en"}, fu_en, 1);
    check_value({nm, "_fu_a"}, fu_a, ea);
    check_value({nm, "_fu_b"}, fu_b, eb);
    check_value({nm, "_busy"}, busy, 1);
    while (!rsp_valid && cyc < 40) begin
      check_value({nm, "_ready_busy"}, req_ready, 0);
      @(posedge clk);
      #1;
      cyc++;
      if (fu_finish && fin_cyc < 0) begin
        fin_cyc = cyc;
        check_value({nm, "_fu_en_off"}, fu_en, 0);
        check_value({nm, "_fu_a_hold"}, fu_a, ea);
        check_value({nm, "_fu_b_hold"}, fu_b, eb);
      end
    end
    check_value({nm, "_finish_cyc"}, fin_cyc, MUL_LAT + 1);
    check_value({nm, "_rsp_lat"}, cyc, MUL_LAT + 2);
    check_value({nm, "_rsp_id"}, rsp_id, gid);
    check_value({nm, "_rsp_tag"}, rsp_tag, et);
    check_value({nm, "_rsp_data"}, rsp_data, ep);
    gid_o  = int'(rsp_id);
    data_o = rsp_data;
    if (hold > 0) req_valid = hold_vld;
    for (int h = 0; h < hold; h++) begin
      #1;
      check_value({nm, "_bp_ready"}, req_ready, 0);
      @(posedge clk);
      #1;
      check_value({nm, "_bp_valid"}, rsp_valid, 1);
      check_value({nm, "_bp_id"}, rsp_id, gid);
      check_value({nm, "_bp_tag"}, rsp_tag, et);
      check_value({nm, "_bp_data"}, rsp_data, ep);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check_value({nm, "_done_busy"}, busy, 0);
    check_value({nm, "_done_valid"}, rsp_valid, 0);
  endtask

  initial begin
    int gid;
    logic [31:0] dat;
`ifdef MUL_ARB_RR_EN
    int exp_seq[5] = '{0, 1, 2, 3, 0};
`else
    int exp_seq[3] = '{0, 0, 0};
`endif

    do_reset("rst", 2);

    // Single op, then backpressure with other requesters knocking.
    set_op(0, 32'd3, 32'd5, 5'd9);
    set_op(1, 32'd7, 32'd6, 5'd3);
    set_op(2, 32'd11, 32'd13, 5'd17);
    do_txn("single", 4'b0001, 4'b0000, 5, 4'b0110, gid, dat);
    check_value("single_result", dat, 32'd15);
    do_txn("after_bp", 4'b0110, 4'b0000, 0, 4'b0000, gid, dat);
    check_value("after_bp_id", gid, 1);

    // Contention from a fresh reset.
    do_reset("rst2", 2);
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 2), 32'(i + 11), 5'(i + 1));
    for (int k = 0; k < $size(exp_seq); k++) begin
      do_txn("cont", 4'b1111, 4'b1111, 0, 4'b1111, gid, dat);
      check_value("cont_seq", gid, exp_seq[k]);
    end
    req_valid = '0;

    // Random traffic, with spurious finishes in IDLE.
    repeat (25) begin
      for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom, 5'($urandom_range(0, 31)));
      do_txn("rnd", 4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
             $urandom_range(0, 2), 4'($urandom_range(0, 15)), gid, dat);
      req_valid = '0;
      if ($urandom_range(0, 1) == 1) begin
        tb_spur = 1'b1;
        @(posedge clk);
        #1;
        tb_spur = 1'b0;
        check_value("spur_idle_valid", rsp_valid, 0);
        check_value("spur_idle_busy", busy, 0);
      end
    end

    // Reset in the middle of WAIT: the old result must never surface.
    set_op(0, 32'hFFFF_FFFF, 32'd2, 5'd7);
    req_valid = 4'b0001;
    #1;
    check_value("mid_grant", req_ready, 4'b0001);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_value("mid_busy", busy, 1);
    do_reset("midrst", 1);
    do_txn("post", 4'b0001, 4'b0000, 0, 4'b0000, gid, dat);
    check_value("post_result", dat, 32'hFFFF_FFFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
